// File: rtl/rect_bounce_if.sv
// Pixel-side bundle for rect_bounce: display timing in, painted pixel out.
// master = timing generator / sink side, slave = the painter.
interface rect_bounce_if #(
    parameter int CORDW = 10
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             de;
    logic             frame;
    logic             out_de;
    logic [3:0]       out_r;
    logic [3:0]       out_g;
    logic [3:0]       out_b;

    modport master (output sx, sy, de, frame, input out_de, out_r, out_g, out_b);
    modport slave  (input sx, sy, de, frame, output out_de, out_r, out_g, out_b);
endinterface

// File: rtl/rect_bounce.sv
// Animated rectangle painter: per-frame X then Y step with edge bounce,
// and a 2-stage pixel pipeline painting fg inside / bg outside / black in blanking.
module rect_bounce #(
    parameter int CORDW = 10,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    rect_bounce_if.slave     pix,
    input  logic             enable,
    input  logic [CORDW-1:0] rect_w,
    input  logic [CORDW-1:0] rect_h,
    input  logic [3:0]       speed,
    input  logic [11:0]      fg_rgb,
    input  logic [11:0]      bg_rgb,
    output logic [CORDW-1:0] rect_x,
    output logic [CORDW-1:0] rect_y,
    output logic             bounce_x,
    output logic             bounce_y
);
    localparam int SW = CORDW + 1;
    localparam logic [CORDW-1:0] H_LIM  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_LIM  = CORDW'(V_RES);
    localparam logic [SW-1:0]    H_LIMW = SW'(H_RES);
    localparam logic [SW-1:0]    V_LIMW = SW'(V_RES);

    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y} state_t;

    typedef struct packed {
        logic [CORDW-1:0] pos;
        logic             dir;
        logic             hit;
    } step_t;

    state_t           state, state_nxt;
    logic [CORDW-1:0] x, y, w_s, h_s;
    logic [CORDW-1:0] x_nxt, y_nxt, w_nxt, h_nxt;
    logic             dx, dy, dx_nxt, dy_nxt, bx_nxt, by_nxt;
    step_t            step_x_r, step_y_r;
    logic             inside_c, inside_q, de_q;

    function automatic logic [CORDW-1:0] clamp_size(
        input logic [CORDW-1:0] v,
        input logic [CORDW-1:0] lim,
        input logic [SW-1:0]    lim_w
    );
        if (v == '0)
            return CORDW'(1);
        else if ({1'b0, v} > lim_w)
            return lim;
        else
            return v;
    endfunction

    // Size clamp wins over motion so a grown rectangle is pulled back on-screen even when halted.
    function automatic step_t step_axis(
        input logic [CORDW-1:0] pos,
        input logic             dir,
        input logic [CORDW-1:0] size,
        input logic [CORDW-1:0] lim,
        input logic [SW-1:0]    lim_w,
        input logic [3:0]       spd,
        input logic             en
    );
        logic [SW-1:0] pend;
        logic [SW-1:0] spd_w;
        step_t         r;
        spd_w = SW'(spd);
        pend  = {1'b0, pos} + {1'b0, size};
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (pend > lim_w) begin
            r.pos = lim - size;
        end else if (en && dir && (pend + spd_w >= lim_w)) begin
            r.pos = lim - size;
            r.dir = 1'b0;
            r.hit = 1'b1;
        end else if (en && !dir && ({1'b0, pos} <= spd_w)) begin
            r.pos = '0;
            r.dir = 1'b1;
            r.hit = 1'b1;
        end else if (en) begin
            r.pos = dir ? pos + CORDW'(spd) : pos - CORDW'(spd);
        end
        return r;
    endfunction

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            dx       <= 1'b1;
            dy       <= 1'b1;
            w_s      <= CORDW'(1);
            h_s      <= CORDW'(1);
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            dx       <= dx_nxt;
            dy       <= dy_nxt;
            w_s      <= w_nxt;
            h_s      <= h_nxt;
            bounce_x <= bx_nxt;
            bounce_y <= by_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        dx_nxt    = dx;
        dy_nxt    = dy;
        w_nxt     = w_s;
        h_nxt     = h_s;
        bx_nxt    = 1'b0;
        by_nxt    = 1'b0;
        step_x_r  = step_axis(x, dx, w_s, H_LIM, H_LIMW, speed, enable);
        step_y_r  = step_axis(y, dy, h_s, V_LIM, V_LIMW, speed, enable);
        case (state)
            IDLE: begin
                if (pix.frame) begin
                    state_nxt = STEP_X;
                    w_nxt     = clamp_size(rect_w, H_LIM, H_LIMW);
                    h_nxt     = clamp_size(rect_h, V_LIM, V_LIMW);
                end
            end
            STEP_X: begin
                state_nxt = STEP_Y;
                x_nxt     = step_x_r.pos;
                dx_nxt    = step_x_r.dir;
                bx_nxt    = step_x_r.hit;
            end
            STEP_Y: begin
                state_nxt = IDLE;
                y_nxt     = step_y_r.pos;
                dy_nxt    = step_y_r.dir;
                by_nxt    = step_y_r.hit;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        inside_c = ({1'b0, pix.sx} >= {1'b0, x}) && ({1'b0, pix.sx} < {1'b0, x} + {1'b0, w_s}) &&
                   ({1'b0, pix.sy} >= {1'b0, y}) && ({1'b0, pix.sy} < {1'b0, y} + {1'b0, h_s});
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            inside_q   <= 1'b0;
            de_q       <= 1'b0;
            pix.out_de <= 1'b0;
            pix.out_r  <= '0;
            pix.out_g  <= '0;
            pix.out_b  <= '0;
        end else begin
            inside_q   <= inside_c;
            de_q       <= pix.de;
            pix.out_de <= de_q;
            {pix.out_r, pix.out_g, pix.out_b} <= de_q ? (inside_q ? fg_rgb : bg_rgb) : '0;
        end
    end

    assign rect_x = x;
    assign rect_y = y;
endmodule

// File: tb/tb_rect_bounce.sv
// Directed bench for rect_bounce: stimulus queues expected values with a due cycle,
// a negedge monitor compares and counts.
module tb_rect_bounce;
    localparam int CORDW = 10;
    localparam int S_X = 0, S_Y = 1, S_BX = 2, S_BY = 3, S_PIX = 4;

    typedef struct {
        int unsigned due;
        int          sel;
        logic [12:0] exp;
        string       name;
    } exp_t;

    logic             clk_pix = 1'b0;
    logic             rst_pix_n;
    logic             enable;
    logic [CORDW-1:0] rect_w, rect_h;
    logic [3:0]       speed;
    logic [11:0]      fg_rgb, bg_rgb;
    logic [CORDW-1:0] rect_x, rect_y;
    logic             bounce_x, bounce_y;

    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        sbq[$];

    rect_bounce_if #(.CORDW(CORDW)) pix ();

    rect_bounce #(.CORDW(CORDW), .H_RES(640), .V_RES(480)) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .pix       (pix),
        .enable    (enable),
        .rect_w    (rect_w),
        .rect_h    (rect_h),
        .speed     (speed),
        .fg_rgb    (fg_rgb),
        .bg_rgb    (bg_rgb),
        .rect_x    (rect_x),
        .rect_y    (rect_y),
        .bounce_x  (bounce_x),
        .bounce_y  (bounce_y)
    );

    always #5 clk_pix = ~clk_pix;
    always @(posedge clk_pix) cyc <= cyc + 1;

    function automatic logic [12:0] actual(input int sel);
        case (sel)
            S_X:     return 13'(rect_x);
            S_Y:     return 13'(rect_y);
            S_BX:    return {12'd0, bounce_x};
            S_BY:    return {12'd0, bounce_y};
            default: return {pix.out_de, pix.out_r, pix.out_g, pix.out_b};
        endcase
    endfunction

    always @(negedge clk_pix) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                n_vec++;
                if (actual(sbq[i].sel) !== sbq[i].exp) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h",
                             sbq[i].name, cyc, actual(sbq[i].sel), sbq[i].exp);
                end
                sbq.delete(i);
            end else if (sbq[i].due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: check due @cyc %0d never sampled", sbq[i].name, sbq[i].due);
                sbq.delete(i);
            end
        end
    end

    task automatic expect_at(input int unsigned due, input int sel, input logic [12:0] val,
                             input string name);
        exp_t e;
        e.due  = due;
        e.sel  = sel;
        e.exp  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic do_frame(input bit chk, input int ex, input bit ebx, input int ey, input bit eby);
        pix.frame = 1'b1;
        if (chk) begin
            expect_at(cyc + 2, S_X,  13'(ex), "rect_x");
            expect_at(cyc + 2, S_BX, {12'd0, ebx}, "bounce_x");
            expect_at(cyc + 3, S_Y,  13'(ey), "rect_y");
            expect_at(cyc + 3, S_BY, {12'd0, eby}, "bounce_y");
            if (ebx) expect_at(cyc + 3, S_BX, 13'd0, "bounce_x_width");
            if (eby) expect_at(cyc + 4, S_BY, 13'd0, "bounce_y_width");
        end
        @(posedge clk_pix); #1;
        pix.frame = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1;
    endtask

    task automatic pixel(input int px, input int py, input bit d, input logic [12:0] e,
                         input string name);
        pix.sx = CORDW'(px);
        pix.sy = CORDW'(py);
        pix.de = d;
        expect_at(cyc + 2, S_PIX, e, name);
        @(posedge clk_pix); #1;
        pix.de = 1'b0;
    endtask

    task automatic do_reset;
        rst_pix_n = 1'b0;
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix);
        rst_pix_n = 1'b1;
        @(posedge clk_pix); #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_pix_n = 1'b0;
        pix.frame = 1'b0;
        pix.de    = 1'b0;
        pix.sx    = '0;
        pix.sy    = '0;
        enable    = 1'b1;
        rect_w    = 10'd100;
        rect_h    = 10'd50;
        speed     = 4'd4;
        fg_rgb    = 12'hFFF;
        bg_rgb    = 12'h137;
        do_reset();

        // reset state, then first step from the origin
        expect_at(cyc, S_X, 13'd0, "reset_x");
        expect_at(cyc, S_Y, 13'd0, "reset_y");
        expect_at(cyc, S_BX, 13'd0, "reset_bx");
        expect_at(cyc, S_PIX, 13'd0, "reset_pix");
        @(posedge clk_pix); #1;
        do_frame(1, 4, 0, 4, 0);

        // asynchronous reset during STEP_X
        pix.de = 1'b1;
        pix.sx = '0;
        pix.sy = '0;
        repeat (2) @(posedge clk_pix);
        #1;
        expect_at(cyc, S_PIX, 13'h1137, "pix_before_reset");
        pix.frame = 1'b1;
        @(posedge clk_pix); #1;
        pix.frame = 1'b0;
        rst_pix_n = 1'b0;
        #1;
        expect_at(cyc, S_X, 13'd0, "async_reset_x");
        expect_at(cyc, S_Y, 13'd0, "async_reset_y");
        expect_at(cyc, S_PIX, 13'd0, "async_reset_pix");
        pix.de = 1'b0;
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix);
        rst_pix_n = 1'b1;
        @(posedge clk_pix); #1;
        do_frame(1, 4, 0, 4, 0);

        // right bounce; full-height rectangle pins y at 0 bouncing every frame
        rect_h = 10'd480;
        do_frame(1, 8, 0, 0, 0);
        for (int i = 1; i <= 132; i++) do_frame(i == 132, 536, 0, 0, 1);
        do_frame(1, 540, 1, 0, 1);
        do_frame(1, 536, 0, 0, 1);

        // left bounce at speed 3
        for (int i = 1; i <= 131; i++) do_frame(i == 131, 12, 0, 0, 1);
        speed = 4'd3;
        do_frame(1, 9, 0, 0, 1);
        do_frame(1, 6, 0, 0, 1);
        do_frame(1, 3, 0, 0, 1);
        do_frame(1, 0, 1, 0, 1);
        do_frame(1, 3, 0, 0, 1);

        // position the 10x10 rectangle at (100,50)
        do_reset();
        rect_w = 10'd10;
        speed  = 4'd10;
        do_frame(1, 10, 0, 0, 1);
        do_frame(1, 20, 0, 0, 1);
        speed = 4'd15;
        do_frame(1, 35, 0, 0, 1);
        do_frame(1, 50, 0, 0, 1);
        rect_h = 10'd10;
        speed  = 4'd10;
        for (int i = 1; i <= 5; i++) do_frame(1, 50 + 10 * i, 0, 10 * i, 0);

        // painting
        pixel(109, 59, 1, 13'h1FFF, "pix_in_corner");
        pixel(110, 59, 1, 13'h1137, "pix_right_out");
        pixel(100, 50, 1, 13'h1FFF, "pix_top_left");
        pixel(99, 50, 1, 13'h1137, "pix_left_out");
        pixel(109, 60, 1, 13'h1137, "pix_below_out");
        pixel(100, 49, 1, 13'h1137, "pix_above_out");
        pixel(105, 55, 0, 13'h0000, "pix_blank");

        // size change takes effect only at frame
        for (int i = 1; i <= 20; i++) do_frame(i == 20, 300, 0, 250, 0);
        rect_w = 10'd640;
        pixel(305, 255, 1, 13'h1FFF, "pix_midframe_in");
        pixel(310, 255, 1, 13'h1137, "pix_midframe_unchanged");
        enable = 1'b0;
        do_frame(1, 0, 0, 250, 0);
        pixel(0, 255, 1, 13'h1FFF, "pix_full_left");
        pixel(639, 255, 1, 13'h1FFF, "pix_full_right");
        pixel(0, 249, 1, 13'h1137, "pix_full_above");
        pixel(0, 260, 1, 13'h1137, "pix_full_below");
        rect_w = 10'd0;
        do_frame(1, 0, 0, 250, 0);
        pixel(0, 255, 1, 13'h1FFF, "pix_w0_in");
        pixel(1, 255, 1, 13'h1137, "pix_w0_out");

        // hold with enable low
        rect_w = 10'd100;
        speed  = 4'd4;
        for (int i = 1; i <= 5; i++) do_frame(1, 0, 0, 250, 0);

        // speed 0: bounce only when touching the edge
        enable = 1'b1;
        speed  = 4'd0;
        rect_w = 10'd640;
        do_frame(1, 0, 1, 250, 0);
        do_frame(1, 0, 1, 250, 0);

        // second frame pulse while busy is ignored
        rect_w = 10'd100;
        speed  = 4'd4;
        pix.frame = 1'b1;
        expect_at(cyc + 2, S_X, 13'd4, "dbl_x");
        expect_at(cyc + 3, S_Y, 13'd254, "dbl_y");
        expect_at(cyc + 4, S_X, 13'd4, "dbl_x_hold");
        expect_at(cyc + 4, S_BX, 13'd0, "dbl_bx_quiet");
        expect_at(cyc + 5, S_Y, 13'd254, "dbl_y_hold");
        @(posedge clk_pix); #1;
        pix.frame = 1'b0;
        @(posedge clk_pix); #1;
        pix.frame = 1'b1;
        @(posedge clk_pix); #1;
        pix.frame = 1'b0;
        repeat (6) @(posedge clk_pix);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rect_bounce.md
# rect_bounce

Parametrised, animated rectangle painter for the 480p pixel pipeline. It sits after the display timing generator (`sx`, `sy`, `de`, `frame`) and before the SDL/video output register stage. It paints a run-time-sized rectangle that moves by a programmable speed once per frame and bounces off all four screen edges. Outputs are 4-bit RGB per channel, black during blanking, with fixed 2-cycle latency.

## Interface
- `CORDW`, 10: coordinate width.
- `H_RES`, 640: active horizontal pixels.
- `V_RES`, 480: active vertical pixels.
- `clk_pix` in 1: pixel clock; the only clock.
- `rst_pix_n` in 1: reset, asynchronous, active-low.
- `sx`, `sy` in CORDW: current screen position.
- `de` in 1: data enable, high in the active area.
- `frame` in 1: one-cycle pulse per frame, issued in blanking.
- `enable` in 1: motion enable.
- `rect_w`, `rect_h` in CORDW: requested rectangle size.
- `speed` in 4: pixels moved per frame on each axis.
- `fg_rgb`, `bg_rgb` in 12: inside and outside colours, {r,g,b} 4 bits each.
- `rect_x`, `rect_y` out CORDW: current top-left corner.
- `bounce_x`, `bounce_y` out 1: one-cycle edge-hit pulses.
- `out_de` out 1: delayed `de`.
- `out_r`, `out_g`, `out_b` out 4: pixel colour.

## Operation
- **Shadow registers `w_s`, `h_s`:**
  - Load on `frame` only.
  - `w_s = clamp(rect_w, 1, H_RES)` and `h_s = clamp(rect_h, 1, V_RES)`. A value of 0 loads as 1.
  - Mid-frame changes to `rect_w`/`rect_h` have no effect on painting.
  - Shadows load on `frame` even when `enable` = 0.
- **FSM: IDLE → STEP_X → STEP_Y → IDLE.**
  - IDLE leaves on `frame`.
  - STEP_X and STEP_Y each last exactly one cycle.
  - `frame` while not in IDLE is ignored.
- **STEP_X**, with direction flag `dx` (1 = right). All sums are computed in CORDW+1 bits.
  - Size clamp (always applied, even when `enable` = 0): if `x + w_s > H_RES`, then `x = H_RES - w_s`.
  - Motion, right: else if `enable` and `dx` and `x + w_s + speed >= H_RES`, then `x = H_RES - w_s`, `dx = 0`, `bounce_x` pulses.
  - Motion, left: else if `enable` and !`dx` and `x <= speed`, then `x = 0`, `dx = 1`, `bounce_x` pulses.
  - Otherwise, if `enable`: `x ± speed`.
- **STEP_Y:** same rules using `y`, `dy`, `h_s`, `V_RES`, `bounce_y`.
- **Speed 0:** no motion. A bounce still occurs if the rectangle already touches the edge in its direction of travel (equality case).
- **Pixel pipeline:**
  - Stage 1 registers `inside = (sx >= x) && (sx < x + w_s) && (sy >= y) && (sy < y + h_s)` together with `de`.
  - Stage 2 registers the colour: `de` ? (`inside` ? `fg_rgb` : `bg_rgb`) : 0.
- **Simultaneous bounces:** X and Y bounces in the same frame give `bounce_x` and `bounce_y` on consecutive cycles.

## Timing
- **Reset (async assert, sync release):**
  - `x` = `y` = 0, `dx` = `dy` = 1, `w_s` = `h_s` = 1, FSM in IDLE.
  - All outputs 0.
  - Reset asserted mid-update abandons the update.
- **Update sequence:**
  - `frame` sampled high at edge t: shadows load, FSM → STEP_X.
  - Edge t+1: `rect_x`/`bounce_x` update.
  - Edge t+2: `rect_y`/`bounce_y` update.
  - `bounce_*` are high for exactly one cycle.
- **Pixel latency:** the colour for (`sx`, `sy`, `de`) sampled at edge n appears on `out_*` after edge n+1, i.e. 2 cycles. `out_de` is aligned with the colour.
- **Shadow visibility:** new shadows and position affect painting from the cycle after they update. Updates happen in blanking, so the visible frame is never torn.

## Test plan
1. **Reset.** Pulse `rst_pix_n` low during STEP_X → outputs, `rect_x`, `rect_y` = 0 immediately, without a clock edge. After release, FSM is in IDLE and the next `frame` moves from (0,0) right/down.
2. **Right bounce.** `rect_w` = 100, `speed` = 4, `enable` = 1; run frames until `rect_x` = 536 → next frame `rect_x` = 540 with one `bounce_x`; the following frame gives 536.
3. **Left bounce.** `speed` = 3 with `rect_x` = 3 moving left → `rect_x` = 0, `bounce_x`, then 3 on the next frame. `rect_h` = 480 → `rect_y` stays 0, with a `bounce_y` on every frame.
4. **Painting.** `x` = 100, `y` = 50, `w` = `h` = 10, `fg` = 0xFFF, `bg` = 0x137:
   - (109,59,`de`=1) → 0xF,0xF,0xF two cycles later.
   - (110,59) → 0x1,0x3,0x7.
   - `de` = 0 → 0,0,0.
5. **Size change.** `rect_w` 10→640 mid-frame → painting is unchanged until `frame`. After `frame` with `x` = 300: `rect_x` = 0 and the whole line is fg. `rect_w` = 0 → width 1.
6. **Hold.** `enable` = 0 across 5 frames → `rect_x`/`rect_y` unchanged and no bounces. Two `frame` pulses 1 cycle apart → the second is ignored, giving a single step.
